setup_sequencer: RTL and testbench

SETUP_SEQUENCER -- requirements
Module: setup_sequencer

---
 rtl/setup_sequencer.sv | 139 +++++++++++++
 tb/tb_setup_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/setup_sequencer.sv
// setup_sequencer: keypad-driven editor for the setup packet (beep on/off, beep time,
// auto-lock time, PIN) with inactivity timeout, abort key and BCD display feed.
package setup_pkg;
    typedef struct packed {
        logic        bip_status;
        logic [6:0]  bip_time;
        logic [6:0]  tranca_aut_time;
        logic [15:0] pin1;
    } setupPac_t;
    typedef logic [3:0][3:0] bcdPac_t;
endpackage

module setup_sequencer
    import setup_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TIMEOUT_S = 20
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      setup_on,
    input  logic      key_valid,
    input  logic [3:0] key_code,
    input  setupPac_t data_setup_old,
    output setupPac_t data_setup_new,
    output logic      setup_end,
    output bcdPac_t   bcd_out,
    output logic      bcd_enable
);
    localparam int LIM = TIMEOUT_S * CLK_FREQ - 1;
    localparam int TW  = $clog2(LIM + 2);
    localparam setupPac_t RST_PAC = '{bip_status: 1'b1, bip_time: 7'd5,
                                      tranca_aut_time: 7'd5, pin1: 16'h1234};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_BIP_ON, S_BIP_TIME, S_TRAVA_TIME, S_PIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    setupPac_t       work_q, work_d, new_q, new_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic [2:0]      cnt_q, cnt_d, mx;
    logic [TW-1:0]   timer_q, timer_d;
    logic            armed_q, armed_d, end_q, bcd_en_q, field_d, ok;
    bcdPac_t         bcd_q, bcd_d;
    logic [6:0]      val;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        timer_d = '0;
        armed_d = armed_q;
        new_d   = new_q;
        bcd_d   = '1;
        val     = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);
        mx      = state_q == S_PIN ? 3'd4 : state_q == S_BIP_ON ? 3'd1 : 3'd2;
        // an empty field always advances keeping the old value
        ok      = state_q == S_BIP_ON || cnt_q == 3'd0 ||
                  (state_q == S_PIN ? cnt_q == 3'd4 : (val >= 7'd5 && val <= 7'd60));
        case (state_q)
            S_IDLE: begin
                armed_d = armed_q | ~setup_on;
                if (setup_on && armed_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                work_d  = data_setup_old;
                dig_d   = '0;
                cnt_d   = '0;
                state_d = S_BIP_ON;
            end
            S_DONE: begin
                armed_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                timer_d = key_valid ? '0 : timer_q + 1'b1;
                if (!setup_on) state_d = S_IDLE;
                else if ((key_valid && key_code == 4'hB) || timer_q == TW'(LIM)) begin
                    new_d   = data_setup_old;
                    state_d = S_DONE;
                end else if (key_valid && key_code == 4'hA) begin
                    if (ok && cnt_q != 3'd0) begin
                        if (state_q == S_BIP_ON) work_d.bip_status = dig_q[0][0];
                        if (state_q == S_BIP_TIME) work_d.bip_time = val;
                        if (state_q == S_TRAVA_TIME) work_d.tranca_aut_time = val;
                        if (state_q == S_PIN) work_d.pin1 = dig_q;
                    end
                    dig_d = '0;
                    cnt_d = '0;
                    if (ok) state_d = state_t'(state_q + 3'd1);
                    if (ok && state_q == S_PIN) new_d = work_d;
                end else if (key_valid && key_code <= 4'd9 &&
                             (state_q != S_BIP_ON || key_code <= 4'd1)) begin
                    dig_d = {dig_q[2:0], key_code};
                    cnt_d = cnt_q == mx ? cnt_q : cnt_q + 3'd1;
                end
            end
        endcase
        if (state_d != state_q) timer_d = '0;
        field_d = state_d inside {[S_BIP_ON:S_PIN]};
        if (field_d) begin
            bcd_d[3] = 4'(state_d) - 4'd1;
            for (int i = 0; i < 3; i++) bcd_d[i] = 3'(i) < cnt_d ? dig_d[i] : 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            work_q   <= RST_PAC;
            new_q    <= RST_PAC;
            dig_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            armed_q  <= 1'b1;
            end_q    <= 1'b0;
            bcd_en_q <= 1'b0;
            bcd_q    <= '1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            new_q    <= new_d;
            dig_q    <= dig_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            armed_q  <= armed_d;
            end_q    <= state_d == S_DONE;
            bcd_en_q <= field_d;
            bcd_q    <= bcd_d;
        end
    end

    assign data_setup_new = new_q;
    assign setup_end      = end_q;
    assign bcd_out        = bcd_q;
    assign bcd_enable     = bcd_en_q;
endmodule

// File: tb/tb_setup_sequencer.sv
// tb_setup_sequencer: directed keypad sessions; setup_end results checked by a scoreboard monitor.
module tb_setup_sequencer;
    import setup_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       setup_on = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    setupPac_t  data_setup_old;
    setupPac_t  data_setup_new;
    logic       setup_end;
    bcdPac_t    bcd_out;
    logic       bcd_enable;

    int total = 0;
    int bad = 0;
    setupPac_t exp_q[$];
    logic prev_end = 1'b0;

    setup_sequencer #(.CLK_FREQ(10), .TIMEOUT_S(2)) dut (
        .clk(clk), .rst(rst), .setup_on(setup_on), .key_valid(key_valid),
        .key_code(key_code), .data_setup_old(data_setup_old),
        .data_setup_new(data_setup_new), .setup_end(setup_end),
        .bcd_out(bcd_out), .bcd_enable(bcd_enable)
    );

    always #5 clk = ~clk;

    function automatic setupPac_t mk(logic b, int t, int tr, logic [15:0] p);
        return '{b, 7'(t), 7'(tr), p};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic key(input logic [3:0] k, input logic [15:0] eb, input string nm);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        chk(nm, 32'(bcd_out), 32'(eb));
    endtask

    task automatic start();
        setup_on = 1'b0;
        repeat (2) @(negedge clk);
        setup_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("enter_bip_on", 32'(bcd_out), 32'h1FFF);
    endtask

    // scoreboard monitor: every setup_end pulse must match the oldest expected packet
    always @(negedge clk) begin
        if (rst && setup_end) begin
            total++;
            if (prev_end) begin
                bad++;
                $display("FAIL end_pulse_width: setup_end high two cycles in a row, required one");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_setup_end: data=%h, required no pulse", data_setup_new);
            end else begin
                setupPac_t e;
                e = exp_q.pop_front();
                if (data_setup_new !== e) begin
                    bad++;
                    $display("FAIL setup_result: got %h expected %h", data_setup_new, e);
                end
            end
        end
        prev_end <= setup_end;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        data_setup_old = mk(1'b0, 10, 10, 16'h1111);
        repeat (2) @(negedge clk);
        chk("rst_bcd_enable", 32'(bcd_enable), 0);
        chk("rst_bcd_out", 32'(bcd_out), 32'hFFFF);
        chk("rst_setup_end", 32'(setup_end), 0);
        chk("rst_data_new", 32'(data_setup_new), 32'(mk(1'b1, 5, 5, 16'h1234)));
        rst = 1'b1;
        // full session with every field committed
        start();
        key(4'd1, 16'h1FF1, "t1_bip_dig");
        key(4'hA, 16'h2FFF, "t1_bip_star");
        key(4'd1, 16'h2FF1, "t1_bt_1");
        key(4'd5, 16'h2F15, "t1_bt_5");
        key(4'hA, 16'h3FFF, "t1_bt_star");
        key(4'd3, 16'h3FF3, "t1_tr_3");
        key(4'd0, 16'h3F30, "t1_tr_0");
        key(4'hA, 16'h4FFF, "t1_tr_star");
        key(4'd9, 16'h4FF9, "t1_pin_9");
        key(4'd8, 16'h4F98, "t1_pin_8");
        key(4'd7, 16'h4987, "t1_pin_7");
        key(4'd6, 16'h4876, "t1_pin_6");
        exp_q.push_back(mk(1'b1, 15, 30, 16'h9876));
        key(4'hA, 16'hFFFF, "t1_done_bcd");
        chk("t1_done_enable", 32'(bcd_enable), 0);
        repeat (3) @(negedge clk);
        chk("t1_no_rearm", 32'(bcd_enable), 0);
        // range checks, digit drop and PIN overflow
        start();
        key(4'd7, 16'h1FFF, "t2_bip_ignore7");
        key(4'hA, 16'h2FFF, "t2_bip_keep");
        key(4'd4, 16'h2FF4, "t2_bt_4");
        key(4'hA, 16'h2FFF, "t2_bt_low_stay");
        key(4'd7, 16'h2FF7, "t2_bt_7");
        key(4'd0, 16'h2F70, "t2_bt_0");
        key(4'hA, 16'h2FFF, "t2_bt_high_stay");
        key(4'd4, 16'h2FF4, "t2_bt_4b");
        key(4'd5, 16'h2F45, "t2_bt_5");
        key(4'hA, 16'h3FFF, "t2_bt_commit");
        key(4'd1, 16'h3FF1, "t2_tr_1");
        key(4'd6, 16'h3F16, "t2_tr_6");
        key(4'd0, 16'h3F60, "t2_tr_drop");
        key(4'hA, 16'h4FFF, "t2_tr_commit60");
        key(4'd1, 16'h4FF1, "t2_pin_1");
        key(4'd2, 16'h4F12, "t2_pin_2");
        key(4'hA, 16'h4FFF, "t2_pin_short_stay");
        key(4'd5, 16'h4FF5, "t2_pin_5");
        key(4'd6, 16'h4F56, "t2_pin_6");
        key(4'd7, 16'h4567, "t2_pin_7");
        key(4'd8, 16'h4678, "t2_pin_8");
        key(4'd9, 16'h4789, "t2_pin_9");
        exp_q.push_back(mk(1'b0, 45, 60, 16'h6789));
        key(4'hA, 16'hFFFF, "t2_done_bcd");
        // abort key returns the old packet
        start();
        key(4'd2, 16'h1FFF, "t3_bip_ignore2");
        key(4'd0, 16'h1FF0, "t3_bip_0");
        key(4'hA, 16'h2FFF, "t3_bip_star");
        exp_q.push_back(mk(1'b0, 10, 10, 16'h1111));
        key(4'hB, 16'hFFFF, "t3_abort_bcd");
        // setup_on fall wins over a simultaneous accept
        start();
        key(4'hA, 16'h2FFF, "t4_s1");
        key(4'hA, 16'h3FFF, "t4_s2");
        key(4'hA, 16'h4FFF, "t4_s3");
        key(4'd1, 16'h4FF1, "t4_pin_1");
        key(4'd2, 16'h4F12, "t4_pin_2");
        key(4'hA, 16'h4FFF, "t4_pin_short_clear");
        key(4'd3, 16'h4FF3, "t4_pin_3");
        key(4'd4, 16'h4F34, "t4_pin_4");
        key(4'd5, 16'h4345, "t4_pin_5");
        key(4'd6, 16'h4456, "t4_pin_6");
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hA;
        setup_on  = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        chk("t4_drop_enable", 32'(bcd_enable), 0);
        repeat (3) @(negedge clk);
        chk("t4_data_unchanged", 32'(data_setup_new), 32'(mk(1'b0, 10, 10, 16'h1111)));
        // inactivity timeout: 2 s at 10 Hz
        start();
        exp_q.push_back(mk(1'b0, 10, 10, 16'h1111));
        n = 0;
        while (!setup_end && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_timeout_cycles", 32'(n), 20);
        // reset in the middle of a session
        data_setup_old = mk(1'b1, 7, 7, 16'h2222);
        start();
        key(4'hA, 16'h2FFF, "t6_s1");
        key(4'hA, 16'h3FFF, "t6_s2");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_enable", 32'(bcd_enable), 0);
        chk("t6_rst_bcd", 32'(bcd_out), 32'hFFFF);
        chk("t6_rst_data", 32'(data_setup_new), 32'(mk(1'b1, 5, 5, 16'h1234)));
        setup_on = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_idle_after_rst", 32'(bcd_enable), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
